io_display_out: RTL and testbench
=================================

# io_display_out

Memory-mapped output peripheral that receives CPU store transactions and drives the board's 16 LEDs and an 8-digit multiplexed seven-segment display. It sits on the IO side of the data-memory decoder, which asserts `LEDCtrl` or `SegCtrl` for store addresses in the output region. Store data is held in internal registers. A free-running scan engine time-multiplexes the eight hex digits onto shared cathode lines.

## Interface

Parameters:
- `SCAN_DIV`, default 100000: clock cycles each digit stays lit. Legal range is 2 or more.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `LEDCtrl`  in  1  decoder select for the LED registers.
- `SegCtrl`  in  1  decoder select for the seven-segment registers.
- `mem_write`  in  1  store strobe from the CPU.
- `address`  in  32  store byte address.
- `write_data`  in  32  store data.
- `led_out`  out  16  LED drive, active-high.
- `seg_an`  out  8  digit enables, active-low; bit i = digit i, digit 0 rightmost.
- `seg_cat`  out  8  cathodes, active-low, ordered {dp,g,f,e,d,c,b,a}.
- `wr_ack`  out  1  one-cycle pulse when a store hits a decoded register.

## Operation

**Clocking and reset**
- All state updates on the falling edge of `clk`, matching the IO input path.
- `rst` high forces the reset state immediately, without waiting for a clock edge.
- Reset state: `led_out`=0, seg_value=0, blank_mask=8'hFF, dp_mask=0, digit index=0, scan counter=0, `seg_an`=8'hFF, `seg_cat`=8'hFF, `wr_ack`=0.

**Store decode**
- A write is accepted when `mem_write` is high, the matching Ctrl is high, and the address matches exactly.
  - `LEDCtrl`, 32'hFFFF_FC60: `led_out` <= `write_data`[15:0].
  - `LEDCtrl`, 32'hFFFF_FC62: `led_out`[7:0] <= `write_data`[7:0]; upper byte unchanged.
  - `SegCtrl`, 32'hFFFF_FC70: seg_value <= `write_data`[31:0]. Digit i displays nibble [4i+3:4i].
  - `SegCtrl`, 32'hFFFF_FC74: blank_mask <= `write_data`[7:0]. Bit set = digit dark.
  - `SegCtrl`, 32'hFFFF_FC78: dp_mask <= `write_data`[7:0]. Bit set = decimal point lit.
- Any other address, or a Ctrl/address mismatch (e.g. `LEDCtrl` with FC70): no register changes and `wr_ack` stays 0.
- `LEDCtrl` and `SegCtrl` both high: the address alone selects the register. Both selects high is a decoder error, but the behaviour is deterministic.

**Scan engine**
- The scan counter runs 0 to `SCAN_DIV`-1 and wraps.
- On the wrap edge, the digit index advances by 1 mod 8 (7 wraps to 0).

**Output generation (registered)**
- Every edge, `seg_an` and `seg_cat` are recomputed from the current index and current registers.
- Digit not blanked:
  - `seg_an` = ~(1<<index).
  - `seg_cat`[6:0] = hex pattern of the selected nibble.
  - `seg_cat`[7] = ~dp_mask[index].
- Digit blanked: `seg_an`=8'hFF and `seg_cat`=8'hFF.
- Hex patterns as full `seg_cat` bytes with dp off: 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, B 83, C C6, D A1, E 86, F 8E.

## Timing

- Store latency: a register update is visible at the falling edge where the store is sampled. `led_out` changes on that same edge.
- `wr_ack` is high for exactly the cycle following an accepted store edge, then returns to 0. Back-to-back stores give back-to-back acks.
- Display latency: `seg_an`/`seg_cat` reflect a register write or an index change one falling edge later.
- Simultaneous store and scan wrap on one edge: both take effect. The next edge's output uses the new index and the new register contents.
- `rst` asserted mid-scan or mid-store: all state returns to reset values immediately, the store is lost, and the display goes dark. After `rst` drops, scanning restarts at digit 0 with counter 0.
- Each digit is lit for exactly `SCAN_DIV` cycles; a full frame is 8×`SCAN_DIV` cycles.

## Test plan

- Reset behaviour: assert `rst` between clock edges -> all outputs take reset values before the next edge. Release -> `seg_an` stays 8'hFF because blank_mask is 8'hFF.
- LED store paths:
  - Store 32'h0000_A5C3 to FC60 with `LEDCtrl` -> `led_out`=16'hA5C3 and one `wr_ack` pulse.
  - Then store 32'h0000_0011 to FC62 -> `led_out`=16'hA511.
- Seven-segment scan (`SCAN_DIV`=4):
  - Setup: store 32'h8765_43F0 to FC70, 0 to FC74, 8'h01 to FC78.
  - Required outputs:
    - digit 0: `seg_an`=FE, `seg_cat`=40.
    - digit 1: `seg_an`=FD, `seg_cat`=8E.
    - digit 7: `seg_an`=7F, `seg_cat`=80.
  - Each digit holds for 4 cycles; index 7 wraps to 0.
- Blanking: blank_mask=8'hF0 -> digits 4–7 give `seg_an`=FF and `seg_cat`=FF; digits 0–3 display normally.
- Decode rejection: store to FC70 with only `LEDCtrl` high, store to FC6C, and store with `mem_write`=0 -> no register changes, `wr_ack` stays 0.
- Collision and reset:
  - Store to FC70 on the scan-wrap edge -> the next digit shows the new nibble.
  - Assert `rst` in the middle of a digit period -> output goes dark immediately; scanning resumes at digit 0 after release.

Source files
------------

// File: rtl/io_display_out.sv
// io_display_out: memory-mapped LED and 8-digit seven-segment output port.
// CPU stores decoded by LEDCtrl/SegCtrl land in holding registers. A
// free-running scan engine multiplexes the eight hex digits onto shared,
// active-low cathode lines. All state moves on the falling clock edge so it
// lines up with the IO input path.
module io_display_out #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LEDCtrl,
  input  logic        SegCtrl,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [15:0] led_out,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat,
  output logic        wr_ack
);

  // Scan counter is sized to hold 0 .. SCAN_DIV-1.
  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  // Register map of the output region.
  localparam logic [31:0] ADDR_LED_FULL = 32'hFFFF_FC60;
  localparam logic [31:0] ADDR_LED_LOW  = 32'hFFFF_FC62;
  localparam logic [31:0] ADDR_SEG_VAL  = 32'hFFFF_FC70;
  localparam logic [31:0] ADDR_SEG_BLK  = 32'hFFFF_FC74;
  localparam logic [31:0] ADDR_SEG_DP   = 32'hFFFF_FC78;

  // Hex digit to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = 7'h7F;
    endcase
    return pat;
  endfunction

  // Holding registers.
  logic [15:0]      led_r;
  logic [31:0]      seg_value_r;
  logic [7:0]       blank_mask_r;
  logic [7:0]       dp_mask_r;
  logic             ack_r;

  // Scan engine.
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       idx_r;

  // Registered display drive.
  logic [7:0]       an_r;
  logic [7:0]       cat_r;

  // Decode results.
  logic             sel_led_full_s;
  logic             sel_led_low_s;
  logic             sel_seg_val_s;
  logic             sel_seg_blk_s;
  logic             sel_seg_dp_s;
  logic             wr_hit_s;

  // Next-state values.
  logic [15:0]      led_nxt_s;
  logic [31:0]      seg_value_nxt_s;
  logic [7:0]       blank_mask_nxt_s;
  logic [7:0]       dp_mask_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [2:0]       idx_nxt_s;
  logic             cnt_wrap_s;

  // Display lookup for the digit currently selected.
  logic [3:0]       nib_s;
  logic             blanked_s;
  logic [7:0]       an_nxt_s;
  logic [7:0]       cat_nxt_s;

  // Store decode: each select only opens its own address window, so with both
  // selects high the address alone picks the register.
  always_comb begin
    sel_led_full_s = 1'b0;
    sel_led_low_s  = 1'b0;
    sel_seg_val_s  = 1'b0;
    sel_seg_blk_s  = 1'b0;
    sel_seg_dp_s   = 1'b0;
    if (mem_write) begin
      if (LEDCtrl) begin
        case (address)
          ADDR_LED_FULL: sel_led_full_s = 1'b1;
          ADDR_LED_LOW:  sel_led_low_s  = 1'b1;
          default:       sel_led_full_s = 1'b0;
        endcase
      end else begin
        sel_led_full_s = 1'b0;
      end
      if (SegCtrl) begin
        case (address)
          ADDR_SEG_VAL: sel_seg_val_s = 1'b1;
          ADDR_SEG_BLK: sel_seg_blk_s = 1'b1;
          ADDR_SEG_DP:  sel_seg_dp_s  = 1'b1;
          default:      sel_seg_val_s = 1'b0;
        endcase
      end else begin
        sel_seg_val_s = 1'b0;
      end
    end else begin
      sel_led_full_s = 1'b0;
    end
  end

  assign wr_hit_s = sel_led_full_s | sel_led_low_s | sel_seg_val_s
                  | sel_seg_blk_s | sel_seg_dp_s;

  // Next values of the holding registers; the low-byte LED store keeps the
  // upper LED byte untouched.
  always_comb begin
    led_nxt_s        = led_r;
    seg_value_nxt_s  = seg_value_r;
    blank_mask_nxt_s = blank_mask_r;
    dp_mask_nxt_s    = dp_mask_r;
    if (sel_led_full_s) begin
      led_nxt_s = write_data[15:0];
    end else if (sel_led_low_s) begin
      led_nxt_s = {led_r[15:8], write_data[7:0]};
    end else begin
      led_nxt_s = led_r;
    end
    if (sel_seg_val_s) begin
      seg_value_nxt_s = write_data;
    end else begin
      seg_value_nxt_s = seg_value_r;
    end
    if (sel_seg_blk_s) begin
      blank_mask_nxt_s = write_data[7:0];
    end else begin
      blank_mask_nxt_s = blank_mask_r;
    end
    if (sel_seg_dp_s) begin
      dp_mask_nxt_s = write_data[7:0];
    end else begin
      dp_mask_nxt_s = dp_mask_r;
    end
  end

  // Scan engine: count 0..SCAN_DIV-1, step the digit index on the wrap.
  always_comb begin
    cnt_wrap_s = (cnt_r == CNT_LAST);
    cnt_nxt_s  = cnt_r;
    idx_nxt_s  = idx_r;
    if (cnt_wrap_s) begin
      cnt_nxt_s = {CNT_W{1'b0}};
      idx_nxt_s = idx_r + 3'd1;
    end else begin
      cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      idx_nxt_s = idx_r;
    end
  end

  // Display lookup from the current index and current register contents.
  always_comb begin
    nib_s     = seg_value_r[{idx_r, 2'b00} +: 4];
    blanked_s = blank_mask_r[idx_r];
    an_nxt_s  = 8'hFF;
    cat_nxt_s = 8'hFF;
    if (blanked_s) begin
      an_nxt_s  = 8'hFF;
      cat_nxt_s = 8'hFF;
    end else begin
      an_nxt_s  = ~(8'h01 << idx_r);
      cat_nxt_s = {~dp_mask_r[idx_r], hex_to_seg(nib_s)};
    end
  end

  // Falling-edge state update with immediate reset.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      led_r        <= 16'h0000;
      seg_value_r  <= 32'h0000_0000;
      blank_mask_r <= 8'hFF;
      dp_mask_r    <= 8'h00;
      ack_r        <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
      idx_r        <= 3'd0;
      an_r         <= 8'hFF;
      cat_r        <= 8'hFF;
    end else begin
      led_r        <= led_nxt_s;
      seg_value_r  <= seg_value_nxt_s;
      blank_mask_r <= blank_mask_nxt_s;
      dp_mask_r    <= dp_mask_nxt_s;
      ack_r        <= wr_hit_s;
      cnt_r        <= cnt_nxt_s;
      idx_r        <= idx_nxt_s;
      an_r         <= an_nxt_s;
      cat_r        <= cat_nxt_s;
    end
  end

  assign led_out = led_r;
  assign seg_an  = an_r;
  assign seg_cat = cat_r;
  assign wr_ack  = ack_r;

endmodule

// File: tb/tb_io_display_out.sv
// Testbench for io_display_out: a stimulus process drives stores and, at every
// falling edge, pushes the expected outputs computed by a behavioural model;
// a monitor pops and compares on every rising edge.
module tb_io_display_out;

  localparam int SD = 4;

  logic        clk;
  logic        rst;
  logic        LEDCtrl;
  logic        SegCtrl;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [15:0] led_out;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;
  logic        wr_ack;

  io_display_out #(.SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .LEDCtrl(LEDCtrl), .SegCtrl(SegCtrl),
    .mem_write(mem_write), .address(address), .write_data(write_data),
    .led_out(led_out), .seg_an(seg_an), .seg_cat(seg_cat), .wr_ack(wr_ack)
  );

  initial clk = 1'b0;
  // Free-running clock, period 10.
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  cat;
    logic        ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state.
  logic [15:0] m_led;
  logic [31:0] m_val;
  logic [7:0]  m_blank;
  logic [7:0]  m_dp;
  int          k;          // falling edges since reset release
  logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [31:0] addr_tab [8] = '{32'hFFFF_FC60, 32'hFFFF_FC62, 32'hFFFF_FC70, 32'hFFFF_FC74,
                                32'hFFFF_FC78, 32'hFFFF_FC6C, 32'hFFFF_FC64, 32'hFFFF_FC7C};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_led   = 16'h0000;
    m_val   = 32'h0;
    m_blank = 8'hFF;
    m_dp    = 8'h00;
    k       = 0;
  endtask

  // One falling edge of the model: outputs come from the pre-edge registers,
  // the LED port and ack reflect the store sampled on this edge.
  task automatic model_edge();
    exp_t e;
    int   d;
    logic [7:0] pat;
    logic acc;
    if (rst) begin
      model_reset();
      e.led = 16'h0; e.an = 8'hFF; e.cat = 8'hFF; e.ack = 1'b0;
    end else begin
      d = (k / SD) % 8;
      if (m_blank[d]) begin
        e.an = 8'hFF; e.cat = 8'hFF;
      end else begin
        pat = hex_tab[(m_val >> (4 * d)) & 32'hF];
        e.an = ~(8'h01 << d);
        e.cat = {~m_dp[d], pat[6:0]};
      end
      acc = 1'b0;
      if (mem_write && LEDCtrl && address == 32'hFFFF_FC60) begin
        m_led = write_data[15:0]; acc = 1'b1;
      end
      if (mem_write && LEDCtrl && address == 32'hFFFF_FC62) begin
        m_led[7:0] = write_data[7:0]; acc = 1'b1;
      end
      if (mem_write && SegCtrl && address == 32'hFFFF_FC70) begin
        m_val = write_data; acc = 1'b1;
      end
      if (mem_write && SegCtrl && address == 32'hFFFF_FC74) begin
        m_blank = write_data[7:0]; acc = 1'b1;
      end
      if (mem_write && SegCtrl && address == 32'hFFFF_FC78) begin
        m_dp = write_data[7:0]; acc = 1'b1;
      end
      e.led = m_led;
      e.ack = acc;
      k++;
    end
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs (called just after a rising edge).
  task automatic step(input logic mw, input logic lc, input logic sc,
                      input logic [31:0] a, input logic [31:0] d);
    mem_write = mw; LEDCtrl = lc; SegCtrl = sc; address = a; write_data = d;
    @(negedge clk);
    model_edge();
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Assert reset between edges, confirm the immediate effect, hold, release.
  task automatic pulse_reset(input int hold);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("rst_led", {16'h0, led_out}, 32'h0);
    check("rst_an",  {24'h0, seg_an},  32'hFF);
    check("rst_cat", {24'h0, seg_cat}, 32'hFF);
    check("rst_ack", {31'h0, wr_ack},  32'h0);
    mem_write = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      model_edge();
      @(posedge clk);
    end
    #2 rst = 1'b0;
  endtask

  // Monitor: every rising edge compares the registered outputs with the
  // oldest pending expectation.
  always @(posedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("led_out", {16'h0, led_out}, {16'h0, e.led});
      check("seg_an",  {24'h0, seg_an},  {24'h0, e.an});
      check("seg_cat", {24'h0, seg_cat}, {24'h0, e.cat});
      check("wr_ack",  {31'h0, wr_ack},  {31'h0, e.ack});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    mem_write = 1'b0; LEDCtrl = 1'b0; SegCtrl = 1'b0;
    address = 32'h0; write_data = 32'h0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1;
    check("init_an",  {24'h0, seg_an},  32'hFF);
    check("init_cat", {24'h0, seg_cat}, 32'hFF);
    check("init_led", {16'h0, led_out}, 32'h0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_edge();
      @(posedge clk);
    end
    #2 rst = 1'b0;

    // Dark display after release, then LED stores.
    idle(6);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FC60, 32'h0000_A5C3);
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FC62, 32'h0000_0011);
    idle(2);
    check("led_a511", {16'h0, led_out}, 32'h0000_A511);

    // Seven-segment setup and a full frame plus wrap.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC70, 32'h8765_43F0);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC74, 32'h0000_0000);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC78, 32'h0000_0001);
    idle(40);

    // Blanking of the upper four digits.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC74, 32'h0000_00F0);
    idle(36);

    // Decode rejection.
    step(1'b1, 1'b1, 1'b0, 32'hFFFF_FC70, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FC6C, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FC70, 32'hCAFE_F00D);
    step(1'b0, 1'b1, 1'b0, 32'hFFFF_FC60, 32'h0000_FFFF);
    idle(4);

    // Store landing on the scan-wrap edge.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC74, 32'h0000_0000);
    while ((k % SD) != SD - 1) idle(1);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC70, 32'h9ABC_DEF1);
    idle(10);

    // Back-to-back stores and both selects high.
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FC60, 32'h0000_1234);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FC78, 32'h0000_00AA);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FC62, 32'h0000_00FE);
    idle(4);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           addr_tab[$urandom_range(0, 7)], $urandom());
    end

    // Reset in the middle of a digit period, then resume from digit 0.
    while ((k % SD) != 1) idle(1);
    pulse_reset(2);
    idle(5);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC70, 32'h7654_3210);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FC74, 32'h0000_0000);
    idle(36);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
